// File: rtl/duration_bcd_display.sv
// Converts an 8-bit duration to three BCD digits (one double-dabble shift per clock)
// and scans them onto a 3-digit common-anode 7-segment display. Optional macro: LEAD_ZERO_BLANK_EN.
module duration_bcd_display #(
    parameter int REFRESH_DIV = 1000,
    parameter int REFRESH_W   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    output logic       busy,
    output logic       done,
    output logic [3:0] bcd_2,
    output logic [3:0] bcd_1,
    output logic [3:0] bcd_0,
    output logic [6:0] seg,
    output logic [2:0] an
);

    typedef enum logic {IDLE, CONV} state_t;

    state_t      state;
    logic [7:0]  last_value;
    logic [19:0] shift_reg;
    logic [2:0]  iter;
    logic [19:0] shift_next;

    // Add-3 is applied per nibble with no carry out, then the whole register shifts.
    function automatic logic [19:0] dabble_step(input logic [19:0] r);
        logic [19:0] t;
        t = r;
        for (int i = 0; i < 3; i++) begin
            if (t[8+4*i +: 4] >= 4'd5)
                t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign shift_next = dabble_step(shift_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_value <= 8'd0;
            shift_reg  <= 20'd0;
            iter       <= 3'd0;
            bcd_2      <= 4'd0;
            bcd_1      <= 4'd0;
            bcd_0      <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (value != last_value) begin
                        shift_reg  <= {12'd0, value};
                        last_value <= value;
                        iter       <= 3'd0;
                        busy       <= 1'b1;
                        state      <= CONV;
                    end
                end
                CONV: begin
                    shift_reg <= shift_next;
                    iter      <= iter + 3'd1;
                    // The eighth shift completes the result; commit it straight from the shifter.
                    if (iter == 3'd7) begin
                        bcd_2 <= shift_next[19:16];
                        bcd_1 <= shift_next[15:12];
                        bcd_0 <= shift_next[11:8];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [REFRESH_W-1:0] refresh_cnt;
    logic [1:0]           digit_idx;
    logic                 wrap;
    logic [1:0]           idx_next;
    logic [3:0]           digit_sel;
    logic                 blank_sel;
    logic [2:0]           an_next;
    logic [6:0]           seg_next;

    assign wrap = (refresh_cnt == REFRESH_W'(REFRESH_DIV - 1));

    // an and seg are derived from the next index so both change on the same edge as the index.
    always_comb begin
        idx_next = digit_idx;
        if (wrap)
            idx_next = (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
        case (idx_next)
            2'd1:    begin digit_sel = bcd_1; an_next = 3'b101; end
            2'd2:    begin digit_sel = bcd_2; an_next = 3'b011; end
            default: begin digit_sel = bcd_0; an_next = 3'b110; end
        endcase
`ifdef LEAD_ZERO_BLANK_EN
        blank_sel = ((idx_next == 2'd2) && (bcd_2 == 4'd0)) ||
                    ((idx_next == 2'd1) && (bcd_2 == 4'd0) && (bcd_1 == 4'd0));
`else
        blank_sel = 1'b0;
`endif
        seg_next = blank_sel ? 7'h7F : seg_decode(digit_sel);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
            an          <= 3'b110;
            seg         <= 7'h40;
        end else begin
            refresh_cnt <= wrap ? '0 : refresh_cnt + 1'b1;
            digit_idx   <= idx_next;
            an          <= an_next;
            seg         <= seg_next;
        end
    end

endmodule

// File: tb/tb_duration_bcd_display.sv
// Self-checking bench for duration_bcd_display: latency, restart on change, reset abort, scan and blanking.
module tb_duration_bcd_display;

    logic       clk;
    logic       rst;
    logic [7:0] value;
    logic       busy;
    logic       done;
    logic [3:0] bcd_2;
    logic [3:0] bcd_1;
    logic [3:0] bcd_0;
    logic [6:0] seg;
    logic [2:0] an;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];

    duration_bcd_display #(.REFRESH_DIV(4), .REFRESH_W(2)) dut (
        .clk(clk), .rst(rst), .value(value), .busy(busy), .done(done),
        .bcd_2(bcd_2), .bcd_1(bcd_1), .bcd_0(bcd_0), .seg(seg), .an(an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] model_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL done_timeout: done=%b after 40 cycles, required 1", done);
        end
    endtask

    // Scoreboard: every completed conversion must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done: got %h with empty queue", {bcd_2, bcd_1, bcd_0});
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if ({bcd_2, bcd_1, bcd_0} !== e) begin
                    errors++;
                    $display("FAIL sb_bcd: got %h required %h", {bcd_2, bcd_1, bcd_0}, e);
                end
            end
        end
    end

    task automatic test_reset();
        bit busy_seen;
        rst = 1'b1;
        value = 8'd0;
        tick();
        tick();
        checks++;
        if (an !== 3'b110 || seg !== 7'h40) begin
            errors++;
            $display("FAIL reset_display: an=%b seg=%h required an=110 seg=40", an, seg);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || {bcd_2, bcd_1, bcd_0} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b bcd=%h required 0 0 000",
                     busy, done, {bcd_2, bcd_1, bcd_0});
        end
        rst = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0) busy_seen = 1'b1;
        end
        checks++;
        if (busy_seen || {bcd_2, bcd_1, bcd_0} !== 12'h000) begin
            errors++;
            $display("FAIL reset_idle_zero: busy/done rose=%b bcd=%h required 0 and 000",
                     busy_seen, {bcd_2, bcd_1, bcd_0});
        end
    endtask

    task automatic test_latency_255();
        value = 8'd255;
        exp_q.push_back(model_bcd(255));
        for (int e = 0; e <= 7; e++) begin
            tick();
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL latency_busy_E%0d: busy=%b done=%b required 1 0", e, busy, done);
            end
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || {bcd_2, bcd_1, bcd_0} !== 12'h255) begin
            errors++;
            $display("FAIL latency_E8: done=%b busy=%b bcd=%h required 1 0 255",
                     done, busy, {bcd_2, bcd_1, bcd_0});
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL latency_E9: done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_change_during_conv();
        bit ok;
        value = 8'd137;
        exp_q.push_back(model_bcd(137));
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL change_start: busy=%b required 1", busy);
        end
        tick();
        tick();
        value = 8'd42;
        exp_q.push_back(model_bcd(42));
        wait_done(ok);
        checks++;
        if ({bcd_2, bcd_1, bcd_0} !== 12'h137) begin
            errors++;
            $display("FAIL change_first: bcd=%h required 137", {bcd_2, bcd_1, bcd_0});
        end
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL change_restart: busy=%b required 1", busy);
        end
        wait_done(ok);
        checks++;
        if ({bcd_2, bcd_1, bcd_0} !== 12'h042) begin
            errors++;
            $display("FAIL change_second: bcd=%h required 042", {bcd_2, bcd_1, bcd_0});
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL change_settle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_scan();
        bit ok;
        logic [2:0] prev_an;
        logic [2:0] an_tab[3];
        logic [6:0] seg_tab[3];
        an_tab  = '{3'b110, 3'b101, 3'b011};
        seg_tab = '{7'h78, 7'h30, 7'h79};
        value = 8'd137;
        exp_q.push_back(model_bcd(137));
        wait_done(ok);
        ok = 1'b0;
        prev_an = an;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (an === 3'b110 && prev_an !== 3'b110) begin
                ok = 1'b1;
                break;
            end
            prev_an = an;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL scan_align: an never entered 110, last an=%b", an);
        end
        for (int k = 0; k < 24; k++) begin
            checks++;
            if (an !== an_tab[(k / 4) % 3] || seg !== seg_tab[(k / 4) % 3]) begin
                errors++;
                $display("FAIL scan_cycle%0d: an=%b seg=%h required an=%b seg=%h",
                         k, an, seg, an_tab[(k / 4) % 3], seg_tab[(k / 4) % 3]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_conv();
        bit ok;
        bit done_seen;
        value = 8'd200;
        exp_q.push_back(model_bcd(200));
        done_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done === 1'b1) done_seen = 1'b1;
        end
        rst = 1'b1;
        tick();
        checks++;
        if (done_seen || done !== 1'b0 || busy !== 1'b0 || {bcd_2, bcd_1, bcd_0} !== 12'h000) begin
            errors++;
            $display("FAIL abort_reset: done_seen=%b done=%b busy=%b bcd=%h required 0 0 0 000",
                     done_seen, done, busy, {bcd_2, bcd_1, bcd_0});
        end
        rst = 1'b0;
        wait_done(ok);
        checks++;
        if ({bcd_2, bcd_1, bcd_0} !== 12'h200) begin
            errors++;
            $display("FAIL abort_reconvert: bcd=%h required 200", {bcd_2, bcd_1, bcd_0});
        end
    endtask

    task automatic test_blanking();
        bit ok;
        logic [2:0] seen;
        logic [6:0] exp_upper;
`ifdef LEAD_ZERO_BLANK_EN
        exp_upper = 7'h7F;
`else
        exp_upper = 7'h40;
`endif
        value = 8'd7;
        exp_q.push_back(model_bcd(7));
        wait_done(ok);
        tick();
        seen = 3'b000;
        for (int k = 0; k < 12; k++) begin
            logic [6:0] exp_seg;
            case (an)
                3'b110: begin exp_seg = 7'h78;     seen[0] = 1'b1; end
                3'b101: begin exp_seg = exp_upper; seen[1] = 1'b1; end
                3'b011: begin exp_seg = exp_upper; seen[2] = 1'b1; end
                default: exp_seg = 7'h7F;
            endcase
            checks++;
            if (seg !== exp_seg || !(an inside {3'b110, 3'b101, 3'b011})) begin
                errors++;
                $display("FAIL blank_cycle%0d: an=%b seg=%h required seg=%h", k, an, seg, exp_seg);
            end
            tick();
        end
        checks++;
        if (seen !== 3'b111) begin
            errors++;
            $display("FAIL blank_slots: slots seen=%b required 111", seen);
        end
    endtask

    initial begin
        rst = 1'b1;
        value = 8'd0;
        test_reset();
        test_latency_255();
        test_change_during_conv();
        test_scan();
        test_reset_mid_conv();
        test_blanking();
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expectations pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/duration_bcd_display.md
Name: duration_bcd_display

Overview:
Downstream stage of the pulse-duration measurement block. Takes the 8-bit held duration value and converts it to three BCD digits with an iterative shift-add-3 (double-dabble) engine, one shift per clock. Drives a 3-digit multiplexed, common-anode 7-segment display on the lab board. Conversion restarts automatically whenever the input value changes.

Parameters:
REFRESH_DIV, 1000, clk cycles each digit stays selected before the scan advances (>=2)
REFRESH_W, 10, width of refresh counter; must satisfy 2^REFRESH_W >= REFRESH_DIV

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
value  input  8  held duration from the measurement stage, unsigned 0..255
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse on the edge the BCD registers update
bcd_2  output  4  hundreds digit, 0..2
bcd_1  output  4  tens digit, 0..9
bcd_0  output  4  ones digit, 0..9
seg  output  7  segments, active low, seg[0]=a .. seg[6]=g
an  output  3  digit enables, active low, an[0]=ones, an[2]=hundreds

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. All state changes on posedge clk.
- Reset values:
  - FSM=IDLE, last_value=0, shift register=0, iteration count=0.
  - bcd_2/1/0=0, busy=0, done=0.
  - Refresh counter=0, digit index=0.
  - an=3'b110, seg=7'h40 (shows "0").
- FSM states: IDLE, CONV.
- IDLE:
  - If value != last_value, load {12'b0, value} into a 20-bit shift register, latch last_value<=value, clear the iteration count, set busy=1, go to CONV.
  - Otherwise hold.
- CONV, one iteration per cycle:
  - Each BCD nibble >=5 gets +3 (nibble-local, no carry into the neighbour); then the whole register shifts left 1.
  - After the 8th iteration: write bcd_2/1/0 from register bits [19:8], done=1 for that cycle, busy=0, return to IDLE.
- Latency: value sampled on edge E0 (load); BCD outputs and done update on edge E8. A new conversion can load on E9 at the earliest.
- value changing during CONV is ignored by the running conversion. The IDLE compare on the next cycle starts a fresh conversion (last_value holds the converted operand). Rapid changes therefore always settle to the final value.
- Value 0 right after reset: no conversion (matches last_value); the display already shows 000.
- bcd outputs hold their previous result during CONV. The display never shows partial results.
- Scanner:
  - Refresh counter counts 0..REFRESH_DIV-1, then wraps.
  - On wrap, digit index advances 0->1->2->0.
  - an is one-hot low: idx0=110, idx1=101, idx2=011.
  - seg is a registered decode of the selected committed digit, updated on the same edge as an.
- Segment codes (hex, active low, gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - Codes 10..15 are unreachable; decode them to 7F (blank).
- Reset asserted mid-conversion aborts it. All state returns to reset values on that edge, with no done pulse.

Optional Feature:
Macro LEAD_ZERO_BLANK_EN.
- Defined:
  - Hundreds digit blanked (seg=7F, its an still cycles) when bcd_2==0.
  - Tens digit blanked when bcd_2==0 and bcd_1==0.
  - Ones digit is never blanked.
- Undefined: all three digits always displayed, e.g. 007.
- The BCD outputs are unaffected either way.

Test Plan:
- Reset, value=0 held 50 cycles -> busy never rises; bcd=0/0/0; an=110, seg=40 after reset.
- value 0->255 at edge E0 -> busy=1 on E0..E7; done pulse at E8; bcd_2/1/0=2/5/5.
- value=137, then changed to 42 three cycles into CONV -> first done gives 1/3/7; a second conversion starts next cycle; its done gives 0/4/2; busy low after it.
- REFRESH_DIV=4, bcd=1/3/7 -> an sequence 110,101,011 each held 4 cycles, repeating; seg=78, then 30, then 79.
- Reset asserted 4 cycles into converting 200 -> no done; bcd=0/0/0; busy=0 next cycle; value=200 still present afterwards -> a fresh conversion gives 2/0/0.
- LEAD_ZERO_BLANK_EN defined, value=7 -> hundreds and tens slots seg=7F, ones slot seg=78. Macro undefined -> 40, 40, 78.
